// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-to-1 stream multiplexer with valid/ready
// handshakes. Channel selection is either external (mode = 0, by sel) or
// round-robin (mode = 1) with a rotating priority pointer. A single output
// register gives one cycle of latency and sustains one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    flattened input words, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel word-available flags
//   in_ready   per-channel accept strobes (combinational, at most one set)
//   mode       0 = fixed select by sel, 1 = round-robin
//   sel        channel index used in fixed mode (values >= CHANNELS never grant)
//   out_data   registered output word
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word this cycle
module stream_mux_rr #(
  parameter int WIDTH    = 20,
  parameter int CHANNELS = 4,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic                         mode,
  input  logic [SELW-1:0]              sel,
  output logic [WIDTH-1:0]             out_data,
  output logic [SELW-1:0]              out_chan,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [SELW-1:0]       r_ptr;
  logic                  r_valid;
  logic [WIDTH-1:0]      r_data;
  logic [SELW-1:0]       r_chan;

  logic                  w_load_en;
  logic                  w_grant_vld;
  logic [SELW-1:0]       w_grant_idx;
  logic                  w_xfer;
  logic [WIDTH-1:0]      w_grant_data;
  logic [2*CHANNELS-1:0] w_dbl;
  logic [CHANNELS-1:0]   w_rot;

  // Register can take a word when empty or when being drained this cycle.
  assign w_load_en = !r_valid || out_ready;

  // Rotate the valid vector so bit j corresponds to channel (ptr+1+j) mod
  // CHANNELS; the lowest set bit is then the round-robin winner. Doubling
  // the vector makes the wrap-around a plain right shift.
  assign w_dbl = {in_valid, in_valid} >> ((SELW+1)'(r_ptr) + (SELW+1)'(1));
  assign w_rot = w_dbl[CHANNELS-1:0];

  always_comb begin
    logic        found;
    int unsigned off;
    int unsigned sum;
    found       = 1'b0;
    off         = 0;
    sum         = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    if (!mode) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if ((32'(sel) == k) && in_valid[k]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = SELW'(k);
        end
      end
    end else begin
      for (int unsigned j = 0; j < CHANNELS; j++) begin
        if (!found && w_rot[j]) begin
          found = 1'b1;
          off   = j;
        end
      end
      sum = 32'(r_ptr) + 32'd1 + off;
      if (sum >= CHANNELS) begin
        sum = sum - CHANNELS;
      end
      w_grant_vld = found;
      w_grant_idx = SELW'(sum);
    end
  end

  assign w_xfer = w_load_en && w_grant_vld && !reset;

  always_comb begin
    in_ready     = '0;
    w_grant_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (w_grant_idx == SELW'(k)) begin
        in_ready[k]  = w_xfer;
        w_grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= SELW'(CHANNELS - 1);
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_grant_data;
      r_chan  <= w_grant_idx;
      r_ptr   <= w_grant_idx;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Instance A: WIDTH 20, 4 channels (directed tests)
  logic [79:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic        a_mode, a_out_valid, a_out_ready;
  logic [1:0]  a_sel, a_out_chan;
  logic [19:0] a_out_data;

  stream_mux_rr #(.WIDTH(20), .CHANNELS(4)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready));

  // Instance B: WIDTH 8, 16 channels (random scoreboard run)
  logic [15:0][7:0] b_in_data;
  logic [15:0] b_in_valid, b_in_ready;
  logic        b_mode, b_out_valid, b_out_ready;
  logic [3:0]  b_sel, b_out_chan;
  logic [7:0]  b_out_data;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(16)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready));

  // Instance C: WIDTH 8, 6 channels (sel values beyond the channel count)
  logic [47:0] c_in_data;
  logic [5:0]  c_in_valid, c_in_ready;
  logic        c_mode, c_out_valid, c_out_ready;
  logic [2:0]  c_sel, c_out_chan;
  logic [7:0]  c_out_data;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(6)) dut_c (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .mode(c_mode), .sel(c_sel), .out_data(c_out_data),
    .out_chan(c_out_chan), .out_valid(c_out_valid), .out_ready(c_out_ready));

  typedef struct {
    int unsigned chan;
    logic [63:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the word in instance A's register against the scoreboard head;
  // the head is retired when the consumer takes it at the coming edge.
  task automatic a_expect_out(input string tag);
    chk({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, "_sb_nonempty"}, 64'(qa.size() != 0), 64'd1);
    if (qa.size() != 0) begin
      chk({tag, "_chan"}, 64'(a_out_chan), 64'(qa[0].chan));
      chk({tag, "_data"}, 64'(a_out_data), qa[0].data);
      if (a_out_ready) void'(qa.pop_front());
    end
  endtask

  // Producer state and reference model for instance B
  logic [15:0]     bv;
  logic [7:0]      bd [16];
  logic            m_valid;
  int              m_ptr;

  initial begin
    reset       = 1'b1;
    a_in_data   = {20'd4, 20'd3, 20'd2, 20'd1};
    a_in_valid  = 4'hF;
    a_mode      = 1'b1;
    a_sel       = '0;
    a_out_ready = 1'b1;
    b_in_data   = '0;
    b_in_valid  = '0;
    b_mode      = 1'b0;
    b_sel       = '0;
    b_out_ready = 1'b0;
    c_in_data   = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    c_in_valid  = '0;
    c_mode      = 1'b0;
    c_sel       = '0;
    c_out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_data", 64'(a_out_data), 64'd0);
    chk("rst_chan", 64'(a_out_chan), 64'd0);
    chk("rst_ready", 64'(a_in_ready), 64'd0);
    chk("rst_b_valid", 64'(b_out_valid), 64'd0);
    reset = 1'b0;

    // Round-robin over four always-valid channels: 0,1,2,3,0
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c > 0) a_expect_out("rr_out");
      chk("rr_ready", 64'(a_in_ready), 64'(4'b0001 << (c % 4)));
      qa.push_back('{32'(c % 4), 64'(c % 4 + 1)});
      tick();
    end
    a_in_valid = '0;
    #1;
    a_expect_out("rr_last");
    chk("rr_idle_ready", 64'(a_in_ready), 64'd0);
    tick();
    chk("rr_drained", 64'(a_out_valid), 64'd0);

    // Fixed select with consumer stall
    a_mode      = 1'b0;
    a_sel       = 2'd2;
    a_in_data   = {20'd4, 20'hABCDE, 20'd2, 20'd1};
    a_in_valid  = 4'b0100;
    a_out_ready = 1'b0;
    #1;
    chk("fix_load_ready", 64'(a_in_ready), 64'b0100);
    qa.push_back('{32'd2, 64'hABCDE});
    tick();
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_ready", 64'(a_in_ready), 64'd0);
      a_expect_out("stall_out");
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("release_ready", 64'(a_in_ready), 64'b0100);
    a_expect_out("release_out");
    qa.push_back('{32'd2, 64'hABCDE});
    tick();
    a_in_valid = '0;
    #1;
    a_expect_out("reload_out");
    tick();
    chk("fix_drained", 64'(a_out_valid), 64'd0);
    chk("fix_sb_empty", 64'(qa.size()), 64'd0);

    // Point ptr at channel 1, then round-robin among channels 1 and 3
    a_sel      = 2'd1;
    a_in_data  = {20'd4, 20'd3, 20'd2, 20'd1};
    a_in_valid = 4'b0010;
    #1;
    chk("ptr_setup_ready", 64'(a_in_ready), 64'b0010);
    qa.push_back('{32'd1, 64'd2});
    tick();
    a_mode     = 1'b1;
    a_in_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      a_expect_out("rr13_out");
      chk("rr13_ready", 64'(a_in_ready), (c % 2 == 0) ? 64'b1000 : 64'b0010);
      qa.push_back((c % 2 == 0) ? '{32'd3, 64'd4} : '{32'd1, 64'd2});
      tick();
    end
    a_in_valid = '0;
    #1;
    a_expect_out("rr13_last");
    tick();
    chk("rr13_drained", 64'(a_out_valid), 64'd0);

    // sel beyond the channel count never grants (6 channels, sel 6 and 7)
    c_in_valid = 6'h3F;
    c_sel      = 3'd6;
    #1;
    chk("sel6_ready", 64'(c_in_ready), 64'd0);
    tick();
    chk("sel6_valid", 64'(c_out_valid), 64'd0);
    c_sel = 3'd7;
    #1;
    chk("sel7_ready", 64'(c_in_ready), 64'd0);
    tick();
    chk("sel7_valid", 64'(c_out_valid), 64'd0);
    c_sel = 3'd5;
    #1;
    chk("sel5_ready", 64'(c_in_ready), 64'b100000);
    tick();
    chk("sel5_valid", 64'(c_out_valid), 64'd1);
    chk("sel5_chan", 64'(c_out_chan), 64'd5);
    chk("sel5_data", 64'(c_out_data), 64'h15);
    c_in_valid = '0;

    // Reset while a word is held
    a_mode      = 1'b0;
    a_sel       = 2'd2;
    a_in_data   = {20'd4, 20'hABCDE, 20'd2, 20'd1};
    a_in_valid  = 4'b0100;
    a_out_ready = 1'b0;
    #1;
    qa.push_back('{32'd2, 64'hABCDE});
    tick();
    a_in_valid = '0;
    #1;
    a_expect_out("held_out");
    reset       = 1'b1;
    a_mode      = 1'b1;
    a_in_data   = {20'd4, 20'd3, 20'd2, 20'd1};
    a_in_valid  = 4'hF;
    a_out_ready = 1'b1;
    #1;
    chk("in_reset_ready", 64'(a_in_ready), 64'd0);
    tick();
    reset = 1'b0;
    qa.delete();
    chk("midrst_valid", 64'(a_out_valid), 64'd0);
    chk("midrst_data", 64'(a_out_data), 64'd0);
    chk("midrst_chan", 64'(a_out_chan), 64'd0);
    #1;
    chk("post_rst_ready", 64'(a_in_ready), 64'b0001);
    qa.push_back('{32'd0, 64'd1});
    tick();
    a_in_valid = '0;
    #1;
    a_expect_out("post_rst_out");
    tick();

    // Random valid/ready traffic on 16 channels against a reference model
    bv      = '0;
    m_valid = 1'b0;
    m_ptr   = 15;
    for (int k = 0; k < 16; k++) bd[k] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int   g;
      logic load;
      for (int k = 0; k < 16; k++) begin
        if (!bv[k] && ($urandom_range(2) == 0)) begin
          bv[k] = 1'b1;
          bd[k] = 8'($urandom);
        end
        b_in_data[k] = bd[k];
      end
      b_in_valid  = bv;
      b_mode      = ($urandom_range(7) != 0);
      b_sel       = 4'($urandom);
      b_out_ready = ($urandom_range(3) != 0);
      #1;
      load = !m_valid || b_out_ready;
      g    = -1;
      if (!b_mode) begin
        if (bv[b_sel]) g = int'(b_sel);
      end else begin
        for (int s = 1; s <= 16; s++) begin
          int k;
          k = (m_ptr + s) % 16;
          if (bv[k]) begin
            g = k;
            break;
          end
        end
      end
      chk("rand_ready", 64'(b_in_ready), (load && g >= 0) ? (64'd1 << g) : 64'd0);
      chk("rand_valid", 64'(b_out_valid), 64'(m_valid));
      if (b_out_valid && b_out_ready) begin
        chk("rand_sb_nonempty", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          chk("rand_chan", 64'(b_out_chan), 64'(qb[0].chan));
          chk("rand_data", 64'(b_out_data), qb[0].data);
          void'(qb.pop_front());
        end
      end
      if (load && g >= 0) begin
        qb.push_back('{32'(g), 64'(bd[g])});
        bv[g]   = 1'b0;
        m_ptr   = g;
        m_valid = 1'b1;
      end else if (b_out_ready) begin
        m_valid = 1'b0;
      end
      tick();
    end
    b_in_valid  = '0;
    b_out_ready = 1'b1;
    #1;
    if (b_out_valid) begin
      chk("drain_sb_nonempty", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        chk("drain_chan", 64'(b_out_chan), 64'(qb[0].chan));
        chk("drain_data", 64'(b_out_data), qb[0].data);
        void'(qb.pop_front());
      end
    end
    tick();
    chk("rand_final_valid", 64'(b_out_valid), 64'd0);
    chk("rand_sb_empty", 64'(qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
